fibonacci_checker: RTL and testbench

// - Consumer/checker at the far end of a Fibonacci number stream from the single- or double-rate generators.
// - Accepts one or two numbers per cycle over a valid/ready handshake.
// - Compares each accepted number against an internally generated expected sequence.
// - Reports the first mismatch (sticky) and counts accepted numbers.
// - Used as a scoreboard/monitor block in sequential-basics labs and in self-checking top levels.

---
 rtl/fib_pkg.sv | 14 +
 rtl/fib_expect.sv | 39 +++
 rtl/fibonacci_checker.sv | 140 ++++++++++++++
 tb/tb_fibonacci_checker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared defaults and state encoding for the Fibonacci generator/checker family.
package fib_pkg;

  localparam int unsigned FIB_W     = 16;
  localparam int unsigned FIB_SEED0 = 1;
  localparam int unsigned FIB_SEED1 = 1;
  localparam int unsigned FIB_CNT_W = 32;

  typedef enum logic {
    CHECK = 1'b0,
    ERR   = 1'b1
  } fib_chk_state_t;

endpackage

// File: rtl/fib_expect.sv
// Expected-value pair (e0,e1) for the checker; advances by one or two sequence steps.
module fib_expect
  import fib_pkg::*;
#(
  parameter int unsigned W     = FIB_W,
  parameter int unsigned SEED0 = FIB_SEED0,
  parameter int unsigned SEED1 = FIB_SEED1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         restart,
  input  logic         adv1,
  input  logic         adv2,
  output logic [W-1:0] e0,
  output logic [W-1:0] e1
);

  logic [W-1:0] sum01;

  assign sum01 = e0 + e1;

  // Double step lands on (e0+e1, e0+2*e1); all sums wrap at W bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e0 <= W'(SEED0);
      e1 <= W'(SEED1);
    end else if (restart) begin
      e0 <= W'(SEED0);
      e1 <= W'(SEED1);
    end else if (adv2) begin
      e0 <= sum01;
      e1 <= sum01 + e1;
    end else if (adv1) begin
      e0 <= e1;
      e1 <= sum01;
    end
  end

endmodule

// File: rtl/fibonacci_checker.sv
// Scoreboard for one- or two-lane Fibonacci streams: sticky first-failure capture
// and a saturating count of accepted numbers.
module fibonacci_checker
  import fib_pkg::*;
#(
  parameter int unsigned W           = FIB_W,
  parameter int unsigned SEED0       = FIB_SEED0,
  parameter int unsigned SEED1       = FIB_SEED1,
  parameter int unsigned CNT_W       = FIB_CNT_W,
  parameter bit          STOP_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             in_valid,
  input  logic             in_valid2,
  input  logic [W-1:0]     in_num,
  input  logic [W-1:0]     in_num2,
  output logic             in_ready,
  output logic             err,
  output logic             err_proto,
  output logic [CNT_W-1:0] err_index,
  output logic [W-1:0]     err_exp,
  output logic [W-1:0]     err_act,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned SUM_W = CNT_W + 1;

  fib_chk_state_t state;

  logic [W-1:0]     e0;
  logic [W-1:0]     e1;
  logic             xfer;
  logic             adv1;
  logic             adv2;
  logic             proto;
  logic             mis0;
  logic             mis1;
  logic             fail;
  logic [CNT_W-1:0] cap_index;
  logic [W-1:0]     cap_exp;
  logic [W-1:0]     cap_act;
  logic [SUM_W-1:0] count_sum;
  logic [CNT_W-1:0] count_inc;

  assign in_ready = !(STOP_ON_ERR && (state == ERR));
  assign xfer     = in_valid & in_ready;
  assign adv2     = xfer & in_valid2;
  assign adv1     = xfer & ~in_valid2;
  assign proto    = in_valid2 & ~in_valid;
  assign mis0     = xfer & (in_num != e0);
  assign mis1     = adv2 & (in_num2 != e1);

  fib_expect #(
    .W     (W),
    .SEED0 (SEED0),
    .SEED1 (SEED1)
  ) u_expect (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .adv1    (adv1),
    .adv2    (adv2),
    .e0      (e0),
    .e1      (e1)
  );

  // First-failure selection: protocol, then lane 0, then lane 1.
  always_comb begin
    fail      = 1'b0;
    cap_index = count;
    cap_exp   = '0;
    cap_act   = '0;
    if (proto) begin
      fail    = 1'b1;
      cap_act = in_num2;
    end else if (mis0) begin
      fail    = 1'b1;
      cap_exp = e0;
      cap_act = in_num;
    end else if (mis1) begin
      fail      = 1'b1;
      cap_index = count + CNT_W'(1);
      cap_exp   = e1;
      cap_act   = in_num2;
    end
  end

  // Saturating add of one or two accepted numbers.
  always_comb begin
    count_sum = {1'b0, count} + SUM_W'(adv2 ? 2 : 1);
    count_inc = count_sum[CNT_W] ? '1 : count_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= CHECK;
      err       <= 1'b0;
      err_proto <= 1'b0;
      err_index <= '0;
      err_exp   <= '0;
      err_act   <= '0;
      count     <= '0;
    end else if (restart) begin
      state     <= CHECK;
      err       <= 1'b0;
      err_proto <= 1'b0;
      err_index <= '0;
      err_exp   <= '0;
      err_act   <= '0;
      count     <= '0;
    end else begin
      if (proto) begin
        err_proto <= 1'b1;
      end
      if (xfer) begin
        count <= count_inc;
      end
      case (state)
        CHECK: begin
          if (fail) begin
            state     <= ERR;
            err       <= 1'b1;
            err_index <= cap_index;
            err_exp   <= cap_exp;
            err_act   <= cap_act;
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state <= CHECK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fibonacci_checker.sv
// Directed and randomized checks of fibonacci_checker against a table-driven Fibonacci model.
module tb_fibonacci_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        restart;
  logic        in_valid;
  logic        in_valid2;
  logic [15:0] in_num;
  logic [15:0] in_num2;
  logic        in_ready;
  logic        err;
  logic        err_proto;
  logic [31:0] err_index;
  logic [15:0] err_exp;
  logic [15:0] err_act;
  logic [31:0] count;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] fib_tab [0:4095];

  int          m_count;
  logic        m_err;
  logic        m_proto;
  int          m_idx;
  logic [15:0] m_exp;
  logic [15:0] m_act;

  fibonacci_checker dut (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .in_valid  (in_valid),
    .in_valid2 (in_valid2),
    .in_num    (in_num),
    .in_num2   (in_num2),
    .in_ready  (in_ready),
    .err       (err),
    .err_proto (err_proto),
    .err_index (err_index),
    .err_exp   (err_exp),
    .err_act   (err_act),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_err   = 1'b0;
    m_proto = 1'b0;
    m_idx   = 0;
    m_exp   = '0;
    m_act   = '0;
  endtask

  task automatic capture(input int idx, input logic [15:0] exp, input logic [15:0] act);
    m_err = 1'b1;
    m_idx = idx;
    m_exp = exp;
    m_act = act;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".in_ready"},  64'(in_ready),  64'(!m_err));
    chk({tag, ".err"},       64'(err),       64'(m_err));
    chk({tag, ".err_proto"}, 64'(err_proto), 64'(m_proto));
    chk({tag, ".err_index"}, 64'(err_index), 64'(m_idx));
    chk({tag, ".err_exp"},   64'(err_exp),   64'(m_exp));
    chk({tag, ".err_act"},   64'(err_act),   64'(m_act));
    chk({tag, ".count"},     64'(count),     64'(m_count));
  endtask

  // One clock of stimulus; the model applies the same cycle, then all outputs are compared.
  task automatic step(input string tag, input logic v, input logic v2,
                      input logic [15:0] n, input logic [15:0] n2, input logic rs);
    logic rdy;
    restart   = rs;
    in_valid  = v;
    in_valid2 = v2;
    in_num    = n;
    in_num2   = n2;
    @(posedge clk);
    rdy = !m_err;
    if (rs) begin
      model_reset();
    end else if (v2 && !v) begin
      m_proto = 1'b1;
      if (!m_err) capture(m_count, 16'd0, n2);
    end else if (v && rdy) begin
      if (!m_err) begin
        if (n != fib_tab[m_count]) capture(m_count, fib_tab[m_count], n);
        else if (v2 && n2 != fib_tab[m_count+1]) capture(m_count + 1, fib_tab[m_count+1], n2);
      end
      m_count += v2 ? 2 : 1;
    end
    @(negedge clk);
    restart   = 1'b0;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    compare_all(tag);
  endtask

  initial begin
    logic [15:0] n;
    logic [15:0] n2;
    logic        v2;
    int          r;

    fib_tab[0] = 16'd1;
    fib_tab[1] = 16'd1;
    for (int i = 2; i < 4096; i++) fib_tab[i] = fib_tab[i-1] + fib_tab[i-2];

    rst = 1'b0; restart = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
    in_num = '0; in_num2 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    chk("reset_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;
    @(negedge clk);

    // Single rate 1,1,2,3,5,8
    step("sr0", 1, 0, 16'd1, 16'd0, 0);
    step("sr1", 1, 0, 16'd1, 16'd0, 0);
    step("sr2", 1, 0, 16'd2, 16'd0, 0);
    step("sr3", 1, 0, 16'd3, 16'd0, 0);
    step("sr4", 1, 0, 16'd5, 16'd0, 0);
    step("sr5", 1, 0, 16'd8, 16'd0, 0);
    chk("sr_err", 64'(err), 64'd0);
    chk("sr_count", 64'(count), 64'd6);

    // Double rate, then e0 must expect 13
    step("dr_rs", 0, 0, 16'd0, 16'd0, 1);
    step("dr0", 1, 1, 16'd1, 16'd1, 0);
    step("dr1", 1, 1, 16'd2, 16'd3, 0);
    step("dr2", 1, 1, 16'd5, 16'd8, 0);
    chk("dr_count", 64'(count), 64'd6);
    step("dr13", 1, 0, 16'd13, 16'd0, 0);
    chk("dr13_err", 64'(err), 64'd0);
    chk("dr13_count", 64'(count), 64'd7);

    // Wrap through 16 bits with the correct values
    step("wr_rs", 0, 0, 16'd0, 16'd0, 1);
    for (int i = 0; i < 23; i++) step("wr_pre", 1, 0, fib_tab[i], 16'd0, 0);
    step("wr23", 1, 0, 16'd46368, 16'd0, 0);
    step("wr24", 1, 0, 16'd9489, 16'd0, 0);
    step("wr25", 1, 0, 16'd55857, 16'd0, 0);
    chk("wr_err", 64'(err), 64'd0);
    chk("wr_count", 64'(count), 64'd26);

    // Wrong value at index 24
    step("wb_rs", 0, 0, 16'd0, 16'd0, 1);
    for (int i = 0; i < 24; i++) step("wb_pre", 1, 0, fib_tab[i], 16'd0, 0);
    step("wb24", 1, 0, 16'd0, 16'd0, 0);
    chk("wb_err", 64'(err), 64'd1);
    chk("wb_index", 64'(err_index), 64'd24);
    chk("wb_exp", 64'(err_exp), 64'd9489);

    // Lane 1 mismatch, then stalled
    step("l1_rs", 0, 0, 16'd0, 16'd0, 1);
    step("l1_0", 1, 1, 16'd1, 16'd1, 0);
    step("l1_1", 1, 1, 16'd2, 16'd4, 0);
    chk("l1_err", 64'(err), 64'd1);
    chk("l1_index", 64'(err_index), 64'd3);
    chk("l1_exp", 64'(err_exp), 64'd3);
    chk("l1_act", 64'(err_act), 64'd4);
    chk("l1_ready", 64'(in_ready), 64'd0);
    step("l1_stall", 1, 0, 16'd5, 16'd0, 0);
    chk("l1_stall_count", 64'(count), 64'd4);
    step("l1_late", 1, 0, 16'd99, 16'd0, 0);
    chk("l1_late_act", 64'(err_act), 64'd4);

    // Protocol violation at count 0
    step("pr_rs", 0, 0, 16'd0, 16'd0, 1);
    step("pr", 0, 1, 16'd0, 16'd7, 0);
    chk("pr_err", 64'(err), 64'd1);
    chk("pr_proto", 64'(err_proto), 64'd1);
    chk("pr_count", 64'(count), 64'd0);
    chk("pr_act", 64'(err_act), 64'd7);

    // Restart beats a same-cycle transfer
    step("rt_rs", 0, 0, 16'd0, 16'd0, 1);
    step("rt0", 1, 1, 16'd1, 16'd1, 0);
    step("rt_x", 1, 0, 16'd2, 16'd0, 1);
    chk("rt_count", 64'(count), 64'd0);
    chk("rt_err", 64'(err), 64'd0);
    step("rt1", 1, 0, 16'd1, 16'd0, 0);
    chk("rt1_err", 64'(err), 64'd0);
    chk("rt1_count", 64'(count), 64'd1);

    // Randomized traffic with occasional corruption, protocol errors and restarts
    step("rn_rs", 0, 0, 16'd0, 16'd0, 1);
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2 || (m_err && r < 12)) begin
        step("rn_restart", $urandom_range(0, 1) == 1, 0, fib_tab[m_count], 16'd0, 1);
      end else if (r < 4) begin
        step("rn_proto", 0, 1, 16'd0, 16'($urandom), 0);
      end else if (r < 14) begin
        step("rn_idle", 0, 0, 16'($urandom), 16'($urandom), 0);
      end else begin
        v2 = $urandom_range(0, 1) == 1;
        n  = fib_tab[m_count];
        n2 = fib_tab[m_count+1];
        if ($urandom_range(0, 29) == 0) n  = n  ^ (16'd1 << $urandom_range(0, 15));
        if ($urandom_range(0, 29) == 0) n2 = n2 ^ (16'd1 << $urandom_range(0, 15));
        step("rn_data", 1, v2, n, n2, 0);
      end
    end

    // Async reset mid-stream, observed before any clock edge
    step("ar_rs", 0, 0, 16'd0, 16'd0, 1);
    step("ar0", 1, 1, 16'd1, 16'd1, 0);
    step("ar1", 1, 0, 16'd7, 16'd0, 0);
    chk("ar_pre_err", 64'(err), 64'd1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all("ar_async");
    chk("ar_count", 64'(count), 64'd0);
    chk("ar_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    step("ar_post", 1, 0, 16'd1, 16'd0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
